l1_line_ctrl: RTL and testbench

Bus-side sequencer for one L1 data cache. It accepts the L1's request strobes (single read, write-through, line refill, dirty-line writeback) and converts each into a sequence of single-beat transactions on a simple request/acknowledge bus master port. It supplies the beat counter, line-write strobes, refill and completion pulses and the error pulse the L1 state machine waits on. It sits between the L1 and the system bus / downstream arbiter.

---
 rtl/l1_line_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_l1_line_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_ctrl.sv
// Purpose: sequences L1 single, refill and writeback requests into single-beat bus request/ack transactions.
// Latency: bus_req rises 1 cycle after a request (2 for writeback); trans_rdy/bus_error pulse 1 cycle after the final ack/err.
// Backpressure: the bus stalls by withholding bus_ack; a stall of TIMEOUT cycles with bus_req high faults the access.
module l1_line_ctrl #(
  parameter int LINE_BEATS = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_req,
  input  logic        write_through_req,
  input  logic        read_line_req,
  input  logic        write_line_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_refill,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  // Byte offset width of one line: LINE_BEATS beats of 8 bytes each.
  localparam int          BEAT_W    = $clog2(LINE_BEATS);
  localparam int          OFF_W     = BEAT_W + 3;
  localparam logic [10:0] LAST_BEAT = 11'(LINE_BEATS - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0]  SIZE_BEAT = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    SGL,
    LRD,
    WFETCH,
    WBUS,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [10:0] beat;
  logic [63:0] base;
  logic [7:0]  tmo;

  logic [63:0] line_base;
  logic [10:0] beat_nxt;
  logic [63:0] beat_off;
  logic [63:0] beat_nxt_off;
  logic        tmo_hit;

  // Line-aligned base of the request address and byte offsets of the current / next beat.
  assign line_base    = {pa[63:OFF_W], {OFF_W{1'b0}}};
  assign beat_nxt     = beat + 11'd1;
  assign beat_off     = {50'b0, beat, 3'b0};
  assign beat_nxt_off = {50'b0, beat_nxt, 3'b0};

  // The cycle that would make bus_req's high time reach TIMEOUT without a response.
  assign tmo_hit = (tmo == TMO_LAST);

  // Sequencer: one state register; every L1-side and bus-side output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      beat               <= '0;
      base               <= '0;
      tmo                <= '0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      bus_req            <= 1'b0;
      bus_we             <= 1'b0;
      bus_addr           <= '0;
      bus_size           <= '0;
      bus_wdata          <= '0;
    end else begin
      // Pulses last one cycle; the stall counter restarts unless a stalled beat keeps it running.
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      tmo                <= '0;

      case (state)
        IDLE: begin
          // Line operations outrank single accesses; writeback outranks refill so a
          // victim is flushed before its slot is overwritten.
          if (write_line_req) begin
            state      <= WFETCH;
            beat       <= '0;
            addr_count <= '0;
            base       <= line_base;
          end else if (read_line_req) begin
            state      <= LRD;
            beat       <= '0;
            addr_count <= '0;
            base       <= line_base;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= line_base;
            bus_size   <= SIZE_BEAT;
          end else if (write_through_req || read_req) begin
            state      <= SGL;
            beat       <= '0;
            addr_count <= '0;
            bus_req    <= 1'b1;
            bus_we     <= write_through_req;
            bus_addr   <= pa;
            bus_size   <= L1_size;
            bus_wdata  <= wt_data;
          end
        end

        SGL, LRD, WBUS: begin
          if (bus_err || (!bus_ack && tmo_hit)) begin
            // Failing beat: no line_write, no refill pulse, just the error pulse.
            state     <= ERR;
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
          end else if (!bus_ack) begin
            tmo <= tmo + 8'd1;
          end else if (state == SGL) begin
            if (!bus_we) begin
              line_data <= bus_rdata;
            end
            state     <= DONE;
            trans_rdy <= 1'b1;
            bus_req   <= 1'b0;
          end else if (state == LRD) begin
            // Refill beats stream back-to-back: bus_req stays high and the address advances per ack.
            line_data  <= bus_rdata;
            addr_count <= beat;
            line_write <= 1'b1;
            beat       <= beat_nxt;
            if (beat == LAST_BEAT) begin
              state              <= DONE;
              trans_rdy          <= 1'b1;
              cache_entry_refill <= 1'b1;
              bus_req            <= 1'b0;
            end else begin
              bus_addr <= base + beat_nxt_off;
            end
          end else begin
            // Writeback beat accepted: drop the bus and present the next SRAM index.
            bus_req <= 1'b0;
            if (beat == LAST_BEAT) begin
              state     <= DONE;
              trans_rdy <= 1'b1;
            end else begin
              beat       <= beat_nxt;
              addr_count <= beat_nxt;
              state      <= WFETCH;
            end
          end
        end

        WFETCH: begin
          // addr_count has been on the SRAM for a cycle; its data is captured as the write beat.
          state     <= WBUS;
          bus_req   <= 1'b1;
          bus_we    <= 1'b1;
          bus_addr  <= base + beat_off;
          bus_size  <= SIZE_BEAT;
          bus_wdata <= wt_data;
        end

        DONE: begin
          state <= IDLE;
        end

        ERR: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_line_ctrl.sv
// Directed bench for l1_line_ctrl: single read/write, zero-wait refill, writeback,
// mid-line error, timeout, request priority and reset mid-line.
module tb_l1_line_ctrl;

  localparam int LB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req, write_through_req, read_line_req, write_line_req;
  logic [3:0]  L1_size;
  logic [63:0] pa;
  logic [63:0] wt_data, wt_drv, wb_sram;
  logic        wb_model;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_refill, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [3:0]  bus_size;
  logic [63:0] bus_rdata = 64'h0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;

  // Writeback data comes from an SRAM model keyed by addr_count; otherwise from the stimulus.
  assign wt_data = wb_model ? wb_sram : wt_drv;

  always #5 clk = ~clk;

  l1_line_ctrl #(.LINE_BEATS(LB), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_through_req(write_through_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_refill(cache_entry_refill), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder / monitor state.
  int          cyc = 0;
  int          ack_wait = 0;
  int          err_beat = -1;
  int          beat_no = 0;
  int          wait_cnt = 0;
  int          req_hi = 0;
  int          lw_cnt = 0;
  int          tr_cnt = 0;
  int          cer_cnt = 0;
  int          be_cnt = 0;
  int          n_bus = 0;
  logic [63:0] rdata_base = 64'h0;
  logic [10:0] lw_idx [64];
  logic [63:0] lw_dat [64];
  logic [63:0] bl_addr [64];
  logic [63:0] bl_wdata [64];
  logic        bl_we [64];
  int          bl_t [64];

  // Mid-cycle: SRAM model follows addr_count with a cycle of latency, log pulses, answer the bus.
  always @(negedge clk) begin
    cyc++;
    wb_sram = 64'h100 + 64'(addr_count);
    if (line_write) begin
      if (lw_cnt < 64) begin
        lw_idx[lw_cnt] = addr_count;
        lw_dat[lw_cnt] = line_data;
      end
      lw_cnt++;
    end
    if (trans_rdy) tr_cnt++;
    if (cache_entry_refill) cer_cnt++;
    if (bus_error) be_cnt++;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    if (bus_req) begin
      req_hi++;
      if (ack_wait >= 0 && wait_cnt >= ack_wait) begin
        if (beat_no == err_beat) bus_err = 1'b1;
        else bus_ack = 1'b1;
        bus_rdata = rdata_base + 64'(beat_no);
        if (n_bus < 64) begin
          bl_addr[n_bus]  = bus_addr;
          bl_wdata[n_bus] = bus_wdata;
          bl_we[n_bus]    = bus_we;
          bl_t[n_bus]     = cyc;
        end
        n_bus++;
        beat_no++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    lw_cnt = 0; tr_cnt = 0; cer_cnt = 0; be_cnt = 0; n_bus = 0; req_hi = 0;
    beat_no = 0; wait_cnt = 0; err_beat = -1; ack_wait = 0; wb_model = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; read_req = 1'b0; write_through_req = 1'b0; read_line_req = 1'b0; write_line_req = 1'b0;
    L1_size = 4'b0; pa = 64'h0; wt_drv = 64'h0; wb_model = 1'b0;
    repeat (3) tick();
    check("rst_bus_req", 64'(bus_req), 64'h0);
    check("rst_addr_count", 64'(addr_count), 64'h0);
    check("rst_line_data", line_data, 64'h0);
    check("rst_pulses", 64'({trans_rdy, bus_error, line_write, cache_entry_refill}), 64'h0);
    check("rst_bus_addr", bus_addr, 64'h0);
    rst = 1'b0;
    tick();

    // Single read, ack after 3 wait cycles.
    clr(); ack_wait = 3; rdata_base = 64'hDEAD;
    pa = 64'h1008; L1_size = 4'b0100; read_req = 1'b1;
    tick();
    check("rd_req_rise", 64'(bus_req), 64'h1);
    check("rd_addr", bus_addr, 64'h1008);
    check("rd_size", 64'(bus_size), 64'h4);
    check("rd_we", 64'(bus_we), 64'h0);
    for (int i = 0; i < 30 && !trans_rdy; i++) tick();
    check("rd_done", 64'(trans_rdy), 64'h1);
    check("rd_data", line_data, 64'hDEAD);
    read_req = 1'b0;
    tick();
    check("rd_rdy_pulse", 64'(trans_rdy), 64'h0);
    check("rd_no_lw", 64'(lw_cnt), 64'h0);
    tick();

    // Single write-through, zero-wait.
    clr(); pa = 64'h1010; L1_size = 4'b0001; wt_drv = 64'hBEEF; write_through_req = 1'b1;
    tick();
    check("wt_we", 64'(bus_we), 64'h1);
    check("wt_wdata", bus_wdata, 64'hBEEF);
    check("wt_size", 64'(bus_size), 64'h1);
    wt_drv = 64'h0;
    for (int i = 0; i < 10 && !trans_rdy; i++) tick();
    check("wt_done", 64'(trans_rdy), 64'h1);
    check("wt_line_data_kept", line_data, 64'hDEAD);
    write_through_req = 1'b0;
    repeat (2) tick();

    // Line refill with zero-wait acks.
    clr(); rdata_base = 64'hA000; pa = 64'h2047; read_line_req = 1'b1;
    tick();
    check("rf_req_rise", 64'(bus_req), 64'h1);
    check("rf_first_addr", bus_addr, 64'h2000);
    for (int i = 0; i < 40 && !trans_rdy; i++) tick();
    check("rf_done", 64'(trans_rdy), 64'h1);
    check("rf_last_coincide", 64'({cache_entry_refill, line_write}), 64'h3);
    check("rf_last_idx", 64'(addr_count), 64'(LB - 1));
    read_line_req = 1'b0;
    tick();
    check("rf_lw_cnt", 64'(lw_cnt), 64'(LB));
    check("rf_cer_cnt", 64'(cer_cnt), 64'h1);
    check("rf_n_bus", 64'(n_bus), 64'(LB));
    check("rf_back_to_back", 64'(bl_t[LB-1] - bl_t[0]), 64'(LB - 1));
    for (int k = 0; k < LB; k++) begin
      check("rf_addr", bl_addr[k], 64'h2000 + 64'(8 * k));
      check("rf_lw_idx", 64'(lw_idx[k]), 64'(k));
      check("rf_lw_dat", lw_dat[k], 64'hA000 + 64'(k));
    end
    tick();

    // Writeback: SRAM data 0x100 + index.
    clr(); wb_model = 1'b1; pa = 64'h3050; write_line_req = 1'b1;
    tick();
    check("wb_fetch_no_req", 64'(bus_req), 64'h0);
    check("wb_fetch_idx", 64'(addr_count), 64'h0);
    tick();
    check("wb_req_rise", 64'(bus_req), 64'h1);
    check("wb_first_wdata", bus_wdata, 64'h100);
    for (int i = 0; i < 80 && !trans_rdy; i++) tick();
    check("wb_done", 64'(trans_rdy), 64'h1);
    check("wb_no_refill", 64'(cache_entry_refill), 64'h0);
    write_line_req = 1'b0;
    tick();
    check("wb_n_bus", 64'(n_bus), 64'(LB));
    for (int k = 0; k < LB; k++) begin
      check("wb_addr", bl_addr[k], 64'h3000 + 64'(8 * k));
      check("wb_wdata", bl_wdata[k], 64'h100 + 64'(k));
      check("wb_we", 64'(bl_we[k]), 64'h1);
      if (k > 0) check("wb_spacing", 64'((bl_t[k] - bl_t[k-1]) >= 2), 64'h1);
    end
    tick();

    // Error on beat 5 of a refill.
    clr(); err_beat = 5; pa = 64'h4000; read_line_req = 1'b1;
    for (int i = 0; i < 40 && !bus_error; i++) tick();
    check("er_pulse", 64'(bus_error), 64'h1);
    check("er_no_done", 64'({trans_rdy, cache_entry_refill}), 64'h0);
    read_line_req = 1'b0;
    repeat (2) tick();
    check("er_lw_cnt", 64'(lw_cnt), 64'h5);
    check("er_tr_cnt", 64'(tr_cnt), 64'h0);
    check("er_cer_cnt", 64'(cer_cnt), 64'h0);
    check("er_be_cnt", 64'(be_cnt), 64'h1);
    check("er_idle", 64'(bus_req), 64'h0);

    // Timeout: no response, TIMEOUT = 10.
    clr(); ack_wait = -1; pa = 64'h5000; L1_size = 4'b1000; read_req = 1'b1;
    for (int i = 0; i < 40 && !bus_error; i++) tick();
    check("to_pulse", 64'(bus_error), 64'h1);
    check("to_req_cycles", 64'(req_hi), 64'd10);
    read_req = 1'b0;
    tick();
    check("to_be_cnt", 64'(be_cnt), 64'h1);
    check("to_tr_cnt", 64'(tr_cnt), 64'h0);
    check("to_idle", 64'(bus_req), 64'h0);
    tick();

    // Priority: writeback before refill when both are raised together.
    clr(); wb_model = 1'b1; pa = 64'h6000; write_line_req = 1'b1; read_line_req = 1'b1;
    tick();
    check("pr_fetch_first", 64'(bus_req), 64'h0);
    tick();
    check("pr_write_first", 64'(bus_we), 64'h1);
    for (int i = 0; i < 80 && !trans_rdy; i++) tick();
    check("pr_wb_done", 64'({trans_rdy, cache_entry_refill}), 64'h2);
    write_line_req = 1'b0;
    tick();
    for (int i = 0; i < 60 && !trans_rdy; i++) tick();
    check("pr_rf_done", 64'({trans_rdy, cache_entry_refill}), 64'h3);
    read_line_req = 1'b0;
    repeat (2) tick();

    // Reset at beat 3 of a refill.
    clr(); ack_wait = 1; pa = 64'h7000; read_line_req = 1'b1;
    for (int i = 0; i < 60 && !(line_write && addr_count == 11'd3); i++) tick();
    check("rs_at_beat3", 64'(line_write && addr_count == 11'd3), 64'h1);
    rst = 1'b1; read_line_req = 1'b0;
    tick();
    check("rs_outs", 64'({bus_req, bus_we, line_write, trans_rdy, bus_error, cache_entry_refill}), 64'h0);
    check("rs_addr_count", 64'(addr_count), 64'h0);
    check("rs_line_data", line_data, 64'h0);
    check("rs_bus_addr", bus_addr, 64'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("rs_no_completion", 64'(tr_cnt + be_cnt), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
